// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU with start/busy/done handshake, iterative
// shift-add multiplier and a saturating multiply-accumulate register.
module seq_alu #(
  parameter  int unsigned WIDTH = 6,
  localparam int unsigned OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_acc,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] result,
  output logic             sat
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ALU  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OUT_W-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [OUT_W-1:0] prod_q, prod_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             busy_d, done_d, sat_d;
  logic [OUT_W-1:0] result_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [OUT_W-1:0] sext_a, sext_b;
  logic [OUT_W-1:0] psum;
  logic [OUT_W:0]   mac_sum;
  logic             pos_ovf, neg_ovf;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
  assign abs_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign abs_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  // Sign extension of captured operands for add/sub
  assign sext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign sext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};

  // One shift-add step of the magnitude product
  assign psum = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Accumulate at one extra bit; top two bits disagreeing means out of range
  assign mac_sum = {acc_q[OUT_W-1], acc_q} + {prod_q[OUT_W-1], prod_q};
  assign pos_ovf = ~mac_sum[OUT_W] &  mac_sum[OUT_W-1];
  assign neg_ovf =  mac_sum[OUT_W] & ~mac_sum[OUT_W-1];

  // Next-state and datapath/output next values
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    sat_d    = sat;

    case (state_q)
      S_IDLE: begin
        if (clr_acc) begin
          acc_d = '0;
        end
        if (start) begin
          op_d     = op;
          a_d      = a;
          b_d      = b;
          neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
          mcand_d  = OUT_W'(abs_a);
          mplier_d = abs_b;
          prod_d   = '0;
          cnt_d    = CW'(WIDTH);
          busy_d   = 1'b1;
          state_d  = op[1] ? S_MUL : S_ALU;
        end
      end
      S_ALU: begin
        prod_d  = (op_q == OP_SUB) ? (sext_a - sext_b) : (sext_a + sext_b);
        state_d = S_FIN;
      end
      S_MUL: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prod_d  = neg_q ? (OUT_W'(0) - psum) : psum;
          state_d = S_FIN;
        end else begin
          prod_d = psum;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (op_q == OP_MAC) begin
          if (pos_ovf) begin
            result_d = SAT_MAX;
          end else if (neg_ovf) begin
            result_d = SAT_MIN;
          end else begin
            result_d = mac_sum[OUT_W-1:0];
          end
          acc_d = result_d;
          sat_d = pos_ovf | neg_ovf;
        end else begin
          result_d = prod_q;
          sat_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      sat      <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      busy     <= busy_d;
      done     <= done_d;
      result   <= result_d;
      sat      <= sat_d;
    end
  end

  // OP_MUL is implied by op[1] with op[0]=0; referenced here for readability
  logic unused_ok;
  assign unused_ok = (OP_MUL == 2'b10);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard testbench for seq_alu (WIDTH=6): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_seq_alu;

  localparam int unsigned WIDTH = 6;
  localparam int unsigned OUT_W = 12;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_acc;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] result;
  logic             sat;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .clr_acc (clr_acc),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .sat     (sat)
  );

  typedef struct {
    logic [OUT_W-1:0] res;
    logic             sat;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_m = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got result=%0d sat=%0d at cycle %0d, required no done",
                 $signed(result), sat, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || sat !== e.sat) begin
          errors++;
          $display("FAIL result: got %0d sat=%0d, required %0d sat=%0d",
                   $signed(result), sat, $signed(e.res), e.sat);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Issue one operation as soon as the DUT is idle and record the model's answer
  task automatic issue(input logic [1:0] o, input int av, input int bv, input logic clr);
    int n;
    int r;
    int lat;
    logic s;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("idle_timeout", 1, 0);
      return;
    end
    start   = 1'b1;
    op      = o;
    a       = WIDTH'(av);
    b       = WIDTH'(bv);
    clr_acc = clr;
    @(posedge clk);
    #1;
    start   = 1'b0;
    clr_acc = 1'b0;
    a       = WIDTH'($urandom);
    b       = WIDTH'($urandom);
    chk("accept_busy", int'(busy), 1);

    s = 1'b0;
    if (clr) acc_m = 0;
    case (o)
      2'b00:   r = av + bv;
      2'b01:   r = av - bv;
      2'b10:   r = av * bv;
      default: begin
        r = acc_m + av * bv;
        if (r > 2047) begin
          r = 2047;
          s = 1'b1;
        end else if (r < -2048) begin
          r = -2048;
          s = 1'b1;
        end
        acc_m = r;
      end
    endcase
    lat = o[1] ? WIDTH + 1 : 2;
    sb.push_back('{res: OUT_W'(r), sat: s, cyc: cyc + lat});
  endtask

  initial begin
    int cnt;
    int w;
    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    clr_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_sat", int'(sat), 0);
    rst = 1'b0;

    issue(2'b00, 10, 13, 1'b0);
    issue(2'b01, 10, 13, 1'b0);

    // Start spam (with clr_acc) during a mul: ignored, busy exactly 7 cycles
    issue(2'b10, 10, 13, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      start   = 1'b1;
      clr_acc = 1'b1;
      op      = 2'($urandom);
      a       = WIDTH'($urandom);
      b       = WIDTH'($urandom);
    end
    start   = 1'b0;
    clr_acc = 1'b0;
    chk("mul_busy_cycles", cnt, WIDTH + 1);

    issue(2'b10, 3, 31, 1'b0);
    issue(2'b10, -32, 31, 1'b0);
    issue(2'b10, -32, -32, 1'b0);

    issue(2'b11, -32, -32, 1'b1);
    issue(2'b11, -32, -32, 1'b0);
    issue(2'b11, -32, 31, 1'b0);

    // clr_acc while busy must not touch the accumulator
    issue(2'b10, 2, 2, 1'b0);
    @(negedge clk);
    clr_acc = 1'b1;
    repeat (3) @(negedge clk);
    clr_acc = 1'b0;
    issue(2'b11, 1, 1, 1'b0);

    issue(2'b11, 2, 3, 1'b1);

    // Reset in the middle of a mul drops it silently and clears acc
    issue(2'b10, 5, 5, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    acc_m = 0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_sat", int'(sat), 0);
    repeat (10) @(negedge clk);

    issue(2'b00, -1, -1, 1'b0);
    issue(2'b11, 7, -9, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom), int'($urandom_range(0, 63)) - 32,
            int'($urandom_range(0, 63)) - 32, ($urandom_range(0, 7) == 0));
    end

    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle signed ALU that succeeds the fixed 6-bit, 2-bit-opcode combinational ALU. It adds a start/busy/done handshake, an iterative shift-add signed multiplier, and a saturating multiply-accumulate mode with its own accumulator register. It sits between a sequencing controller and the result datapath, and accepts one operation at a time.

## Interface
- WIDTH, 6, operand width in bits (two's complement); legal range 4..16
- OUT_W, 2*WIDTH, result and accumulator width; fixed to 2*WIDTH and not overridable
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 mac
- a  in  WIDTH  signed operand A, sampled on accept
- b  in  WIDTH  signed operand B, sampled on accept
- clr_acc  in  1  clears the accumulator; honoured only when busy=0
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; result valid
- result  out  OUT_W  signed result, held until the next done
- sat  out  1  mac saturated; valid with done, held with result

## Operation
- Reset: busy=0, done=0, result=0, sat=0, acc=0. FSM state is IDLE.
- FSM states are IDLE, ALU, MUL and FIN.
- IDLE: on start=1, capture a, b and op, and set busy=1.
  - add/sub go to ALU.
  - mul/mac go to MUL.
  - start while busy=1 is ignored with no side effect.
- ALU (one cycle): result = sext(a) +/- sext(b) at OUT_W. This cannot overflow. Set sat=0. Go to FIN.
- MUL (WIDTH cycles):
  - Work on the magnitudes |a| and |b| (each fits in WIDTH bits unsigned).
  - Each cycle, test the LSB of the multiplier, conditionally add the shifted multiplicand, shift, and decrement the counter.
  - On the last cycle, negate the product if sign(a) XOR sign(b).
  - The product always fits in OUT_W. For example, with WIDTH=6, (-32)*(-32)=1024 is below 2047.
- FIN: raise done for exactly one cycle and clear busy. Then go to IDLE.
  - mul: result = product, sat=0.
  - mac: sum = acc + product, computed at OUT_W+1 bits. If the sum is above 2^(OUT_W-1)-1 or below -2^(OUT_W-1), clamp to that bound and set sat=1. Otherwise sat=0. Both acc and result take the clamped value.
- clr_acc in IDLE sets acc=0 on the next edge.
  - If clr_acc and start(mac) arrive in the same cycle, the clear applies first, so the mac result is 0 + product.
  - clr_acc while busy is ignored.
- add, sub and mul never modify acc.

## Timing
- Accept edge E0: start=1 and busy=0 sampled. busy=1 after E0.
- add/sub: done=1 and result valid after E2 (ALU at E1, FIN at E2). Latency is 2 cycles.
- mul/mac: MUL iterates over E1..E_WIDTH. FIN is at E_(WIDTH+1). Latency is WIDTH+1 cycles (7 for WIDTH=6).
- busy falls on the same edge that done rises.
- Back-to-back operation: start may be asserted in the done cycle and is accepted on the next edge, because busy=0 there. There are no dead cycles beyond FSM latency.
- result and sat change only on done edges and on reset.
- Mid-operation rst: the next edge forces the reset values, drops the operation silently (no done), and clears acc.
- a and b may change freely after E0 without affecting the in-flight result.

## Test plan
All cases use WIDTH=6, OUT_W=12.
- add/sub: a=10, b=13, op=00 -> done 2 cycles after accept, result=23. Same operands with op=01 -> result=-3 (12'hFFD), sat=0.
- mul latency and signs:
  - a=10, b=13, op=10 -> result=130, done exactly 7 cycles after accept, busy high for 7 cycles.
  - a=3, b=31 -> 93.
  - a=-32, b=31 -> -992.
  - a=-32, b=-32 -> 1024.
- mac saturation: clr_acc, then mac a=-32, b=-32 twice -> first result=1024 sat=0, second result=2047 sat=1, acc=2047. A following mac a=-32, b=31 -> 1055, sat=0.
- Handshake: pulse start every cycle during a mul -> only the first is accepted, exactly one done. Start during the done cycle -> the next op is accepted on the following edge.
- clr_acc interactions: clr_acc while busy is ignored (acc unchanged). clr_acc together with start(mac) a=2, b=3 -> result=6.
- Reset mid-mul at cycle 4 -> busy=0, done never pulses, result=0, acc=0. A fresh add a=-1, b=-1 -> -2.
